// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, register-destination
// select codes, the EX/MEM pipeline bundle and small decode helpers.
package cpu_pkg;

    // ALU operation codes carried in ex_ALUOp
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    // Destination register select codes carried in ex_RegDst
    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] REGDST_RA  = 2'd2;
    localparam logic [1:0] REGDST_RA2 = 2'd3;

    // Link register index used by the call-style destinations
    localparam logic [4:0] REG_RA = 5'd31;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic        reg_wr;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_to_reg;
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic [31:0] pc_plus_4;
        logic [4:0]  write_addr;
    } ex_mem_t;

    // A forwarding source supplies an operand only when it really writes
    // a non-zero register that matches the operand's source register.
    function automatic logic fwd_hit(
        input logic       we,
        input logic [4:0] src_addr,
        input logic [4:0] operand_addr
    );
        return we && (src_addr != 5'd0) && (src_addr == operand_addr);
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU for the EX stage.
// Ports: a, b operands; op ALU code; result; zero = (result == 0).
module ex_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero
);

    logic [4:0] shamt;

    assign shamt = a[4:0];

    always_comb begin
        result = 32'd0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
            ALU_LUI:  result = b << 16;
            default:  result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution with a
// one-cycle squash of the flushed bubble, and the EX/MEM register.
// Inputs: ID/EX controls and data, MEM/WB forwarding sources, stall.
// Outputs: branch_taken/branch_target redirect, registered mem_* bundle.
module ex_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        ex_RegWr,
    input  logic        ex_Branch,
    input  logic        ex_BranchClip,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic        ex_ALUSrcA,
    input  logic        ex_ALUSrcB,
    input  logic [1:0]  ex_MemtoReg,
    input  logic [3:0]  ex_ALUOp,
    input  logic [1:0]  ex_RegDst,
    input  logic [31:0] ex_ReadData1,
    input  logic [31:0] ex_ReadData2,
    input  logic [31:0] ex_imm_ext,
    input  logic [31:0] ex_PC_Plus_4,
    input  logic [4:0]  ex_Shamt,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_rd,
    input  logic        fw_mem_RegWr,
    input  logic [4:0]  fw_mem_Addr,
    input  logic [31:0] fw_mem_Data,
    input  logic        fw_wb_RegWr,
    input  logic [4:0]  fw_wb_Addr,
    input  logic [31:0] fw_wb_Data,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        mem_RegWr,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic [1:0]  mem_MemtoReg,
    output logic [31:0] mem_ALUOut,
    output logic [31:0] mem_WriteData,
    output logic [31:0] mem_PC_Plus_4,
    output logic [4:0]  mem_WriteAddr
);

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic [4:0]  wr_addr;

    logic        squash_d;
    logic        squash_q;
    ex_mem_t     ex_mem_d;
    ex_mem_t     ex_mem_q;

    // Forwarding: the younger MEM result wins over WB
    always_comb begin
        fwd_a = ex_ReadData1;
        if (fwd_hit(fw_mem_RegWr, fw_mem_Addr, ex_rs)) begin
            fwd_a = fw_mem_Data;
        end else if (fwd_hit(fw_wb_RegWr, fw_wb_Addr, ex_rs)) begin
            fwd_a = fw_wb_Data;
        end
    end

    always_comb begin
        fwd_b = ex_ReadData2;
        if (fwd_hit(fw_mem_RegWr, fw_mem_Addr, ex_rt)) begin
            fwd_b = fw_mem_Data;
        end else if (fwd_hit(fw_wb_RegWr, fw_wb_Addr, ex_rt)) begin
            fwd_b = fw_wb_Data;
        end
    end

    assign alu_a = ex_ALUSrcA ? {27'd0, ex_Shamt} : fwd_a;
    assign alu_b = ex_ALUSrcB ? ex_imm_ext : fwd_b;

    ex_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (ex_ALUOp),
        .result (alu_y),
        .zero   (alu_zero)
    );

    always_comb begin
        wr_addr = REG_RA;
        case (ex_RegDst)
            REGDST_RT: wr_addr = ex_rt;
            REGDST_RD: wr_addr = ex_rd;
            default:   wr_addr = REG_RA;
        endcase
    end

    // BranchClip inverts the sense of the zero test (BEQ vs BNE).
    // The squash term keeps the bubble behind a taken branch from
    // redirecting a second time.
    assign branch_taken = ~reset & ex_Branch
                        & (alu_zero ^ ex_BranchClip)
                        & ~stall & ~squash_q;

    assign branch_target = ex_PC_Plus_4 + {ex_imm_ext[29:0], 2'b00};

    assign squash_d = stall ? squash_q : branch_taken;

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (!stall) begin
            ex_mem_d.reg_wr     = ex_RegWr & ~squash_q;
            ex_mem_d.mem_read   = ex_MemRead & ~squash_q;
            ex_mem_d.mem_write  = ex_MemWrite & ~squash_q;
            ex_mem_d.mem_to_reg = ex_MemtoReg;
            ex_mem_d.alu_out    = alu_y;
            ex_mem_d.write_data = fwd_b;
            ex_mem_d.pc_plus_4  = ex_PC_Plus_4;
            ex_mem_d.write_addr = wr_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_q <= 1'b0;
            ex_mem_q <= '0;
        end else begin
            squash_q <= squash_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    assign mem_RegWr     = ex_mem_q.reg_wr;
    assign mem_MemRead   = ex_mem_q.mem_read;
    assign mem_MemWrite  = ex_mem_q.mem_write;
    assign mem_MemtoReg  = ex_mem_q.mem_to_reg;
    assign mem_ALUOut    = ex_mem_q.alu_out;
    assign mem_WriteData = ex_mem_q.write_data;
    assign mem_PC_Plus_4 = ex_mem_q.pc_plus_4;
    assign mem_WriteAddr = ex_mem_q.write_addr;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a random
// back-to-back run, with a scoreboard of expected EX/MEM captures.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        ex_RegWr, ex_Branch, ex_BranchClip, ex_MemRead;
    logic        ex_MemWrite, ex_ALUSrcA, ex_ALUSrcB;
    logic [1:0]  ex_MemtoReg;
    logic [3:0]  ex_ALUOp;
    logic [1:0]  ex_RegDst;
    logic [31:0] ex_ReadData1, ex_ReadData2, ex_imm_ext, ex_PC_Plus_4;
    logic [4:0]  ex_Shamt, ex_rs, ex_rt, ex_rd;
    logic        fw_mem_RegWr;
    logic [4:0]  fw_mem_Addr;
    logic [31:0] fw_mem_Data;
    logic        fw_wb_RegWr;
    logic [4:0]  fw_wb_Addr;
    logic [31:0] fw_wb_Data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_RegWr, mem_MemRead, mem_MemWrite;
    logic [1:0]  mem_MemtoReg;
    logic [31:0] mem_ALUOut, mem_WriteData, mem_PC_Plus_4;
    logic [4:0]  mem_WriteAddr;

    typedef struct packed {
        logic        regwr;
        logic        memread;
        logic        memwrite;
        logic [1:0]  m2r;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  wa;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    logic m_squash;
    int   errors = 0;
    int   checks = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall),
        .ex_RegWr(ex_RegWr), .ex_Branch(ex_Branch),
        .ex_BranchClip(ex_BranchClip), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_ALUSrcA(ex_ALUSrcA),
        .ex_ALUSrcB(ex_ALUSrcB), .ex_MemtoReg(ex_MemtoReg),
        .ex_ALUOp(ex_ALUOp), .ex_RegDst(ex_RegDst),
        .ex_ReadData1(ex_ReadData1), .ex_ReadData2(ex_ReadData2),
        .ex_imm_ext(ex_imm_ext), .ex_PC_Plus_4(ex_PC_Plus_4),
        .ex_Shamt(ex_Shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .fw_mem_RegWr(fw_mem_RegWr), .fw_mem_Addr(fw_mem_Addr),
        .fw_mem_Data(fw_mem_Data), .fw_wb_RegWr(fw_wb_RegWr),
        .fw_wb_Addr(fw_wb_Addr), .fw_wb_Data(fw_wb_Data),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_RegWr(mem_RegWr), .mem_MemRead(mem_MemRead),
        .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_ALUOut(mem_ALUOut), .mem_WriteData(mem_WriteData),
        .mem_PC_Plus_4(mem_PC_Plus_4), .mem_WriteAddr(mem_WriteAddr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] fwd_m(input logic [4:0] r,
                                          input logic [31:0] rf);
        if (fw_mem_RegWr && fw_mem_Addr == r && r != 0) return fw_mem_Data;
        if (fw_wb_RegWr && fw_wb_Addr == r && r != 0) return fw_wb_Data;
        return rf;
    endfunction

    function automatic logic [31:0] alu_m(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sb_s;
        sb_s = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << a[4:0];
            4'd9:  return b >> a[4:0];
            4'd10: return sb_s >>> a[4:0];
            4'd11: return {b[15:0], 16'd0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        stall = 0; ex_RegWr = 0; ex_Branch = 0; ex_BranchClip = 0;
        ex_MemRead = 0; ex_MemWrite = 0; ex_ALUSrcA = 0; ex_ALUSrcB = 0;
        ex_MemtoReg = 0; ex_ALUOp = 0; ex_RegDst = 0;
        ex_ReadData1 = 0; ex_ReadData2 = 0; ex_imm_ext = 0;
        ex_PC_Plus_4 = 0; ex_Shamt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        fw_mem_RegWr = 0; fw_mem_Addr = 0; fw_mem_Data = 0;
        fw_wb_RegWr = 0; fw_wb_Addr = 0; fw_wb_Data = 0;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic drive_cycle();
        logic [31:0] a, b, ya, yb, y, tgt;
        logic        bt;
        exp_t        e;
        #1;
        a  = fwd_m(ex_rs, ex_ReadData1);
        b  = fwd_m(ex_rt, ex_ReadData2);
        ya = ex_ALUSrcA ? {27'd0, ex_Shamt} : a;
        yb = ex_ALUSrcB ? ex_imm_ext : b;
        y  = alu_m(ex_ALUOp, ya, yb);
        bt = ex_Branch & ((y == 0) ^ ex_BranchClip) & ~stall & ~m_squash;
        tgt = ex_PC_Plus_4 + ex_imm_ext * 4;
        checks++;
        if (branch_taken !== bt) begin
            errors++;
            $display("FAIL sb_branch_taken: got %b want %b", branch_taken, bt);
        end
        checks++;
        if (branch_target !== tgt) begin
            errors++;
            $display("FAIL sb_branch_target: got %h want %h", branch_target, tgt);
        end
        if (!stall) begin
            e.regwr    = ex_RegWr & ~m_squash;
            e.memread  = ex_MemRead & ~m_squash;
            e.memwrite = ex_MemWrite & ~m_squash;
            e.m2r      = ex_MemtoReg;
            e.alu      = y;
            e.wd       = b;
            e.pc4      = ex_PC_Plus_4;
            e.wa       = (ex_RegDst == 0) ? ex_rt :
                         (ex_RegDst == 1) ? ex_rd : 5'd31;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!stall) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: got 0 entries want 1");
            end else begin
                last_exp = sb.pop_front();
            end
            m_squash = bt;
        end
        checks++;
        if ({mem_RegWr, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_ALUOut,
             mem_WriteData, mem_PC_Plus_4, mem_WriteAddr} !== last_exp) begin
            errors++;
            $display("FAIL sb_exmem: got %h want %h",
                     {mem_RegWr, mem_MemRead, mem_MemWrite, mem_MemtoReg,
                      mem_ALUOut, mem_WriteData, mem_PC_Plus_4, mem_WriteAddr},
                     last_exp);
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_squash = 0;
        last_exp = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        ex_Branch = 1; ex_RegWr = 1;
        #1;
        checks++;
        if ({mem_RegWr, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_ALUOut,
             mem_WriteData, mem_PC_Plus_4, mem_WriteAddr} !== 106'd0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero want 0");
        end
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_branch: got %b want 0", branch_taken);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        clear_inputs();
    endtask

    task automatic test_forward();
        clear_inputs();
        fw_mem_RegWr = 1; fw_mem_Addr = 5; fw_mem_Data = 32'h11;
        fw_wb_RegWr = 1; fw_wb_Addr = 5; fw_wb_Data = 32'h22;
        ex_rs = 5; ex_rt = 5; ex_ReadData1 = 32'h99; ex_ReadData2 = 32'h98;
        ex_ALUSrcB = 1; ex_imm_ext = 0; ex_ALUOp = 0;
        drive_cycle();
        checks++;
        if (mem_ALUOut !== 32'h11) begin
            errors++;
            $display("FAIL fwd_priority: got %h want 00000011", mem_ALUOut);
        end
        checks++;
        if (mem_WriteData !== 32'h11) begin
            errors++;
            $display("FAIL fwd_b_wdata: got %h want 00000011", mem_WriteData);
        end
        fw_mem_RegWr = 0;
        drive_cycle();
        checks++;
        if (mem_ALUOut !== 32'h22) begin
            errors++;
            $display("FAIL fwd_wb: got %h want 00000022", mem_ALUOut);
        end
    endtask

    task automatic test_zero_reg_slt();
        clear_inputs();
        fw_mem_RegWr = 1; fw_mem_Addr = 0; fw_mem_Data = 32'hDEAD;
        ex_rs = 0; ex_ReadData1 = 0; ex_ALUSrcB = 1; ex_imm_ext = 0;
        drive_cycle();
        checks++;
        if (mem_ALUOut !== 32'h0) begin
            errors++;
            $display("FAIL fwd_zero_reg: got %h want 00000000", mem_ALUOut);
        end
        clear_inputs();
        ex_rs = 1; ex_rt = 2;
        ex_ReadData1 = 32'hFFFF_FFFF; ex_ReadData2 = 32'd1; ex_ALUOp = 6;
        drive_cycle();
        checks++;
        if (mem_ALUOut !== 32'd1) begin
            errors++;
            $display("FAIL slt_signed: got %h want 00000001", mem_ALUOut);
        end
        ex_ALUOp = 7;
        drive_cycle();
        checks++;
        if (mem_ALUOut !== 32'd0) begin
            errors++;
            $display("FAIL sltu: got %h want 00000000", mem_ALUOut);
        end
    endtask

    task automatic test_alu_ops();
        clear_inputs();
        ex_rs = 1; ex_rt = 2;
        for (int op = 0; op < 16; op++) begin
            ex_ALUOp = op[3:0];
            ex_ReadData1 = $urandom();
            ex_ReadData2 = $urandom();
            drive_cycle();
        end
        ex_ALUOp = 10; ex_ALUSrcA = 1; ex_Shamt = 4;
        ex_ReadData2 = 32'h8000_0000;
        drive_cycle();
        checks++;
        if (mem_ALUOut !== 32'hF800_0000) begin
            errors++;
            $display("FAIL sra_shamt: got %h want f8000000", mem_ALUOut);
        end
    endtask

    task automatic test_branch_squash();
        clear_inputs();
        ex_rs = 1; ex_rt = 2; ex_ReadData1 = 7; ex_ReadData2 = 7;
        ex_ALUOp = 1; ex_Branch = 1;
        ex_PC_Plus_4 = 32'h100; ex_imm_ext = 32'hFFFF_FFFE;
        #1;
        checks++;
        if (branch_taken !== 1'b1 || branch_target !== 32'hF8) begin
            errors++;
            $display("FAIL beq_taken: got %b/%h want 1/000000f8",
                     branch_taken, branch_target);
        end
        drive_cycle();
        ex_RegWr = 1; ex_MemWrite = 1; ex_MemRead = 1;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL beq_squashed: got %b want 0", branch_taken);
        end
        drive_cycle();
        checks++;
        if ({mem_RegWr, mem_MemRead, mem_MemWrite} !== 3'b000) begin
            errors++;
            $display("FAIL squash_ctrl: got %b want 000",
                     {mem_RegWr, mem_MemRead, mem_MemWrite});
        end
    endtask

    task automatic test_bne_stall();
        clear_inputs();
        ex_rs = 1; ex_rt = 2; ex_ReadData1 = 3; ex_ReadData2 = 3;
        ex_ALUOp = 1; ex_Branch = 1; ex_BranchClip = 1;
        ex_RegWr = 1; ex_RegDst = 1; ex_rd = 9;
        drive_cycle();
        checks++;
        if (branch_taken !== 1'b0 || mem_WriteAddr !== 5'd9) begin
            errors++;
            $display("FAIL bne_not_taken: got %b/%0d want 0/9",
                     branch_taken, mem_WriteAddr);
        end
        ex_BranchClip = 0; stall = 1; ex_rd = 3; ex_ReadData1 = 5;
        ex_ReadData2 = 5;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL stall_branch: got %b want 0", branch_taken);
        end
        drive_cycle();
        checks++;
        if (mem_WriteAddr !== 5'd9 || mem_RegWr !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got %0d/%b want 9/1",
                     mem_WriteAddr, mem_RegWr);
        end
        stall = 0;
        #1;
        checks++;
        if (branch_taken !== 1'b1) begin
            errors++;
            $display("FAIL after_stall_branch: got %b want 1", branch_taken);
        end
        drive_cycle();
        ex_Branch = 0;
        drive_cycle();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        ex_RegWr = 1; ex_rt = 4;
        drive_cycle();
        checks++;
        if (mem_RegWr !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_regwr: got %b want 1", mem_RegWr);
        end
        #2;
        reset = 1;
        #1;
        checks++;
        if (mem_RegWr !== 1'b0 || mem_WriteAddr !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got %b/%0d want 0/0",
                     mem_RegWr, mem_WriteAddr);
        end
        @(negedge clk);
        reset = 0;
        model_reset();
        clear_inputs();
        ex_RegDst = 2; ex_rt = 4; ex_rd = 6; ex_RegWr = 1;
        drive_cycle();
        checks++;
        if (mem_WriteAddr !== 5'd31) begin
            errors++;
            $display("FAIL regdst_ra: got %0d want 31", mem_WriteAddr);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            stall         = ($urandom_range(0, 5) == 0);
            ex_RegWr      = $urandom_range(0, 1);
            ex_Branch     = $urandom_range(0, 1);
            ex_BranchClip = $urandom_range(0, 1);
            ex_MemRead    = $urandom_range(0, 1);
            ex_MemWrite   = $urandom_range(0, 1);
            ex_ALUSrcA    = ($urandom_range(0, 3) == 0);
            ex_ALUSrcB    = ($urandom_range(0, 2) == 0);
            ex_MemtoReg   = 2'($urandom_range(0, 3));
            ex_ALUOp      = 4'($urandom_range(0, 15));
            ex_RegDst     = 2'($urandom_range(0, 3));
            ex_ReadData1  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            ex_ReadData2  = ($urandom_range(0, 3) == 0) ? ex_ReadData1 : $urandom();
            ex_imm_ext    = $urandom();
            ex_PC_Plus_4  = $urandom();
            ex_Shamt      = 5'($urandom_range(0, 31));
            ex_rs         = 5'($urandom_range(0, 3));
            ex_rt         = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 31));
            fw_mem_RegWr  = $urandom_range(0, 1);
            fw_mem_Addr   = 5'($urandom_range(0, 3));
            fw_mem_Data   = $urandom();
            fw_wb_RegWr   = $urandom_range(0, 1);
            fw_wb_Addr    = 5'($urandom_range(0, 3));
            fw_wb_Data    = $urandom();
            drive_cycle();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forward();
        test_zero_reg_slt();
        test_alu_ops();
        test_branch_squash();
        test_bne_stall();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port: clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: stall  in  1  hold EX/MEM outputs and inhibit flush generation.
REQ-004 SHALL have ports: ex_RegWr, ex_Branch, ex_BranchClip, ex_MemRead, ex_MemWrite, ex_ALUSrcA, ex_ALUSrcB  in  1 each  decoded controls from the ID/EX register.
REQ-005 SHALL have ports: ex_MemtoReg  in  2; ex_ALUOp  in  4; ex_RegDst  in  2; these are controls from the ID/EX register.
REQ-006 SHALL have ports: ex_ReadData1, ex_ReadData2, ex_imm_ext, ex_PC_Plus_4  in  32 each; ex_Shamt, ex_rs, ex_rt, ex_rd  in  5 each.
REQ-007 SHALL have ports: fw_mem_RegWr  in  1; fw_mem_Addr  in  5; fw_mem_Data  in  32; these are the MEM-stage forwarding source.
REQ-008 SHALL have ports: fw_wb_RegWr  in  1; fw_wb_Addr  in  5; fw_wb_Data  in  32; these are the WB-stage forwarding source.
REQ-009 SHALL have ports: branch_taken  out  1; branch_target  out  32; these form the combinational redirect and the ID/EX and IF/ID flush.
REQ-010 SHALL have registered EX/MEM outputs: mem_RegWr, mem_MemRead, mem_MemWrite  out  1; mem_MemtoReg  out  2; mem_ALUOut, mem_WriteData, mem_PC_Plus_4  out  32; mem_WriteAddr  out  5.

Function
REQ-011 Operand A SHALL be forwarded per bit: MEM source first, then WB source, else ex_ReadData1.
REQ-012 A source SHALL match only when its RegWr=1, its Addr is nonzero and its Addr equals ex_rs.
REQ-013 Operand B SHALL be forwarded the same way using ex_rt; the forwarded B SHALL become mem_WriteData.
REQ-014 ALU input A SHALL be {27'b0, ex_Shamt} when ex_ALUSrcA=1, else forwarded A.
REQ-015 ALU input B SHALL be ex_imm_ext when ex_ALUSrcB=1, else forwarded B.
REQ-016 ALUOp SHALL decode as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI (B<<16); codes 12-15 SHALL produce 0.
REQ-017 Shifts SHALL shift B by A[4:0]; ADD and SUB SHALL wrap modulo 2^32 with no overflow trap.
REQ-018 The zero flag SHALL be (ALU result == 0); branch_taken SHALL be ex_Branch & (zero XOR ex_BranchClip) & ~stall & ~squash.
REQ-019 branch_target SHALL be ex_PC_Plus_4 + (ex_imm_ext << 2), taken modulo 2^32.
REQ-020 squash SHALL be an internal flop set for exactly one cycle after a cycle with branch_taken=1, so that the flushed bubble that follows cannot redirect.
REQ-021 The write address SHALL be ex_rt for RegDst=0, ex_rd for 1, and 31 for 2 and 3.
REQ-022 On each rising edge with stall=0, the EX/MEM outputs SHALL capture ALU result, forwarded B, ex_PC_Plus_4, the write address and the controls.
REQ-023 When squash=1, the capture SHALL zero mem_RegWr, mem_MemRead and mem_MemWrite.
REQ-024 With stall=1, all EX/MEM outputs and squash SHALL hold.
REQ-025 The EX-to-MEM-register latency SHALL be one cycle; branch_taken SHALL be valid in the same cycle as its inputs.

Reset
REQ-026 While reset=1, all mem_* outputs and squash SHALL be 0 immediately, independent of clk.
REQ-027 branch_taken SHALL be 0 during reset.
REQ-028 The first capture after reset deasserts SHALL occur on the next rising edge with stall=0.

Structure
REQ-029 The ALUOp codes and RegDst codes SHALL live in shared package cpu_pkg as named constants.
REQ-030 The ALU SHALL be the single combinational sub-module ex_alu(a, b, op, result, zero).
REQ-031 The forwarding muxes, branch logic, squash flop and EX/MEM register SHALL stay in ex_stage.

Verification
REQ-032 Forward priority: MEM and WB both write r5 (MEM=0x11, WB=0x22), ex_rs=5, ADD with imm 0 -> mem_ALUOut=0x11 next edge.
REQ-033 Zero register: fw_mem_Addr=0 with RegWr=1, ex_rs=0, ReadData1=0 -> no forward; SLT(-1,1)=1 and SLTU(-1,1)=0.
REQ-034 BEQ taken: A=B=7, PC_Plus_4=0x100, imm=-2 -> branch_taken=1, target=0xF8; a BEQ presented the next cycle -> branch_taken=0 and a zero-control capture.
REQ-035 BNE not taken: BranchClip=1, A=B -> branch_taken=0; assert stall with a taken branch -> branch_taken=0 and outputs hold.
REQ-036 Async reset: assert reset mid-cycle after mem_RegWr=1 -> mem_RegWr=0 before the next edge; RegDst=2 then gives mem_WriteAddr=31.
